// File: rtl/svm_model_serializer.sv
// svm_model_serializer: streams a stored SVM model (count, coefficients, offset) as bytes; SVM_SERIALIZER_CHECKSUM_EN appends an XOR checksum byte
module svm_model_serializer #(
   parameter int NUM_FEATURES_IN = 16
) (
   input  logic                                 clk_in,
   input  logic                                 rst_in,
   input  logic                                 coef_wr_en,
   input  logic [7:0]                           coef_wr_vec,
   input  logic [$clog2(NUM_FEATURES_IN)-1:0]   coef_wr_idx,
   input  logic signed [15:0]                   coef_wr_data,
   input  logic [7:0]                           num_supports_in,
   input  logic signed [31:0]                   offset_in,
   input  logic                                 start_in,
   output logic [7:0]                           byte_data_out,
   output logic                                 byte_valid_out,
   input  logic                                 byte_ready_in,
   output logic                                 busy_out,
   output logic                                 done_out
);
   localparam int IW = $clog2(NUM_FEATURES_IN);
   localparam logic [IW-1:0] KMAX = IW'(NUM_FEATURES_IN - 1);

   typedef enum logic [2:0] {
      IDLE,
      SEND_COUNT,
      FETCH,
      SEND_HI,
      SEND_LO,
      SEND_OFFSET,
`ifdef SVM_SERIALIZER_CHECKSUM_EN
      SEND_CHECK,
`endif
      DONE
   } state_t;

   state_t        state, state_nx;
   logic [15:0]   mem [256][NUM_FEATURES_IN-1];
   logic [15:0]   rd_data;
   logic [7:0]    n_lat, vec, chk;
   logic [31:0]   off_lat;
   logic [IW-1:0] k;
   logic [1:0]    ocnt;
   logic          xfer, accept, last;

   assign accept   = state == IDLE && start_in && num_supports_in != 8'd0;
   assign xfer     = byte_valid_out && byte_ready_in;
   assign last     = vec == n_lat - 8'd1 && k == KMAX;
   assign busy_out = state != IDLE;
   assign done_out = state == DONE;

   // Coefficient RAM: writes only while idle, synchronous read of the entry addressed by (vec, k)
   always_ff @(posedge clk_in) begin
      if (state == IDLE && coef_wr_en && coef_wr_idx != '0 && coef_wr_idx <= KMAX)
         mem[coef_wr_vec][coef_wr_idx - IW'(1)] <= coef_wr_data;
      rd_data <= mem[vec][k - IW'(1)];
   end

   // State register
   always_ff @(posedge clk_in) begin
      if (rst_in) state <= IDLE;
      else        state <= state_nx;
   end

   // Latched request, stream counters and running checksum
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         n_lat   <= '0;
         off_lat <= '0;
         vec     <= '0;
         k       <= IW'(1);
         ocnt    <= '0;
         chk     <= '0;
      end else begin
         if (accept) begin
            n_lat   <= num_supports_in;
            off_lat <= offset_in;
            vec     <= '0;
            k       <= IW'(1);
            ocnt    <= '0;
            chk     <= '0;
         end
         if (xfer) chk <= chk ^ byte_data_out;
         if (state == SEND_LO && xfer) begin
            k   <= k == KMAX ? IW'(1) : k + IW'(1);
            vec <= k == KMAX ? vec + 8'd1 : vec;
         end
         if (state == SEND_OFFSET && xfer) ocnt <= ocnt + 2'd1;
      end
   end

   // Next state and output byte; valid depends only on state, never on ready
   always_comb begin
      state_nx       = state;
      byte_valid_out = 1'b0;
      byte_data_out  = 8'd0;
      case (state)
         IDLE:        state_nx = accept ? SEND_COUNT : IDLE;
         SEND_COUNT: begin
            byte_valid_out = 1'b1;
            byte_data_out  = n_lat;
            state_nx       = xfer ? FETCH : SEND_COUNT;
         end
         FETCH:       state_nx = SEND_HI;
         SEND_HI: begin
            byte_valid_out = 1'b1;
            byte_data_out  = rd_data[15:8];
            state_nx       = xfer ? SEND_LO : SEND_HI;
         end
         SEND_LO: begin
            byte_valid_out = 1'b1;
            byte_data_out  = rd_data[7:0];
            state_nx       = !xfer ? SEND_LO : last ? SEND_OFFSET : FETCH;
         end
         SEND_OFFSET: begin
            byte_valid_out = 1'b1;
            byte_data_out  = 8'(off_lat >> {~ocnt, 3'b000});
`ifdef SVM_SERIALIZER_CHECKSUM_EN
            state_nx       = xfer && ocnt == 2'd3 ? SEND_CHECK : SEND_OFFSET;
`else
            state_nx       = xfer && ocnt == 2'd3 ? DONE : SEND_OFFSET;
`endif
         end
`ifdef SVM_SERIALIZER_CHECKSUM_EN
         SEND_CHECK: begin
            byte_valid_out = 1'b1;
            byte_data_out  = chk;
            state_nx       = xfer ? DONE : SEND_CHECK;
         end
`endif
         DONE:        state_nx = IDLE;
         default:     state_nx = IDLE;
      endcase
   end
endmodule
